// File: rtl/dram_arbiter.sv
// dram_arbiter: two-master arbiter in front of a single-ported data RAM, one beat at a time.
// Optional feature: define ARB_RR_EN for round-robin tie-breaking (default: master 1 wins ties).
`default_nettype none

module dram_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BEATS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc_i,
    input  logic          m0_std_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_data_i,
    output logic [DW-1:0] m0_data_o,
    output logic          m0_ack_o,
    input  logic          m1_cyc_i,
    input  logic          m1_std_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    output logic [DW-1:0] m1_data_o,
    output logic          m1_ack_o,
    output logic          s_cyc_o,
    output logic          s_std_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_addr_o,
    output logic [DW-1:0] s_data_o,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_ack_i,
    output logic [1:0]    grant_o
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] BEAT_LIMIT = CW'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        NEXT  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            owner, owner_nxt;
    logic [1:0]      grant, grant_nxt;
    logic [CW-1:0]   beats, beats_nxt;

    logic m0_req, m1_req, own_cyc, own_std, other_req, winner;

    assign m0_req    = m0_cyc_i & m0_std_i;
    assign m1_req    = m1_cyc_i & m1_std_i;
    assign own_cyc   = owner ? m1_cyc_i : m0_cyc_i;
    assign own_std   = owner ? m1_std_i : m0_std_i;
    assign other_req = owner ? m0_req : m1_req;

`ifdef ARB_RR_EN
    // rr_last holds the most recently granted master; the other one wins a tie.
    logic rr_last, rr_nxt;

    assign winner = (m0_req & m1_req) ? ~rr_last : m1_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_last <= 1'b1;
        else     rr_last <= rr_nxt;
    end
`else
    assign winner = m1_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            grant <= 2'b00;
            beats <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            grant <= grant_nxt;
            beats <= beats_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        grant_nxt = grant;
        beats_nxt = beats;
`ifdef ARB_RR_EN
        rr_nxt    = rr_last;
`endif
        case (state)
            IDLE: begin
                if (m0_req | m1_req) begin
                    owner_nxt = winner;
                    grant_nxt = winner ? 2'b10 : 2'b01;
                    beats_nxt = '0;
                    state_nxt = ISSUE;
`ifdef ARB_RR_EN
                    rr_nxt    = winner;
`endif
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (s_ack_i) begin
                    if (beats != BEAT_LIMIT) beats_nxt = beats + CW'(1);
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (!own_cyc) begin
                    grant_nxt = 2'b00;
                    state_nxt = IDLE;
                end else if (own_std) begin
                    state_nxt = ISSUE;
                    // Beat budget spent while the other master waits: hand the RAM over.
                    if (beats == BEAT_LIMIT && other_req) begin
                        owner_nxt = ~owner;
                        grant_nxt = {grant[0], grant[1]};
                        beats_nxt = '0;
`ifdef ARB_RR_EN
                        rr_nxt    = ~owner;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_o = grant;
    assign s_cyc_o = (state != IDLE);
    assign s_std_o = (state == ISSUE);

    always_comb begin
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (state != IDLE) begin
            s_we_o   = owner ? m1_we_i   : m0_we_i;
            s_sel_o  = owner ? m1_sel_i  : m0_sel_i;
            s_addr_o = owner ? m1_addr_i : m0_addr_i;
            s_data_o = owner ? m1_data_i : m0_data_i;
        end
    end

    // A master that abandoned its cycle mid-beat gets no acknowledge.
    assign m0_ack_o  = (state == WAIT) & ~owner & s_ack_i & m0_cyc_i;
    assign m1_ack_o  = (state == WAIT) &  owner & s_ack_i & m1_cyc_i;
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

endmodule

`default_nettype wire
